rom_dump_sequencer: RTL and testbench

- Sequences a full read-out of a 556PT5 (IP3604) or 556PT4 (IP3601) PROM.
- Sweeps addresses 0..LAST_ADDRESS, drives the chip operation code and waits a programmable access time per address.
- Samples the chip data lines, then hands each (address, data) pair downstream on a valid/ready stream.
- Sits between the chip pins and the dump transport (UART/host link), replacing manual increment/decrement stepping.

---
 rtl/rom_reader_pkg.sv | 39 +++
 rtl/rom_dump_sequencer_if.sv | 28 ++
 rtl/rom_access_timer.sv | 29 ++
 rtl/rom_dump_sequencer.sv | 145 ++++++++++++++
 tb/tb_rom_dump_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_reader_pkg.sv
// Shared definitions for the 556PT5 / 556PT4 PROM readers.
// Covers chip geometry, operation codes and the dump sequencer state encoding.
package rom_reader_pkg;

   localparam int IP3604 = 1;
   localparam int IP3601 = 2;

   localparam int IP3604_DATA_WIDTH    = 8;
   localparam int IP3604_ADDRESS_WIDTH = 9;
   localparam int IP3604_LAST_ADDRESS  = 511;

   localparam int IP3601_DATA_WIDTH    = 4;
   localparam int IP3601_ADDRESS_WIDTH = 8;
   localparam int IP3601_LAST_ADDRESS  = 255;

   // Operation pins V1..V4 map to bits 0..3.
   localparam logic [3:0] OP_READ_CODE = 4'b1100;
   localparam logic [3:0] OP_IDLE_CODE = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PRESENT,
      ST_DONE
   } seq_state_t;

   function automatic int chip_data_width(input int chip);
      return (chip == IP3601) ? IP3601_DATA_WIDTH : IP3604_DATA_WIDTH;
   endfunction

   function automatic int chip_address_width(input int chip);
      return (chip == IP3601) ? IP3601_ADDRESS_WIDTH : IP3604_ADDRESS_WIDTH;
   endfunction

   function automatic int chip_last_address(input int chip);
      return (chip == IP3601) ? IP3601_LAST_ADDRESS : IP3604_LAST_ADDRESS;
   endfunction

endpackage

// File: rtl/rom_dump_sequencer_if.sv
// Valid/ready stream carrying one (address, data) pair per transfer.
interface rom_dump_sequencer_if
   import rom_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = IP3604_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH
);

   logic [DATA_WIDTH-1:0]    sample_data;
   logic [ADDRESS_WIDTH-1:0] sample_address;
   logic                     sample_valid;
   logic                     sample_ready;

   modport master (
      output sample_data,
      output sample_address,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_data,
      input  sample_address,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/rom_access_timer.sv
// Loadable down-counter that times how long an address is held before sampling.
module rom_access_timer #(
   parameter int ACCESS_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   output logic expired
);

   localparam int             COUNT_WIDTH = $clog2(ACCESS_CYCLES + 1);
   localparam logic [COUNT_WIDTH-1:0] LOAD_VALUE = COUNT_WIDTH'(ACCESS_CYCLES - 1);

   logic [COUNT_WIDTH-1:0] r_count;

   // Saturates at zero so an idle timer stays expired until reloaded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= LOAD_VALUE;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign expired = (r_count == '0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Sweeps a PROM from address 0 to LAST_ADDRESS, sampling each word after the
// access time and streaming (address, data) pairs out over a valid/ready link.
module rom_dump_sequencer
   import rom_reader_pkg::*;
#(
   parameter int         DATA_WIDTH    = chip_data_width(IP3604),
   parameter int         ADDRESS_WIDTH = chip_address_width(IP3604),
   parameter int         LAST_ADDRESS  = chip_last_address(IP3604),
   parameter int         ACCESS_CYCLES = 4,
   parameter logic [3:0] OP_READ       = OP_READ_CODE,
   parameter logic [3:0] OP_IDLE       = OP_IDLE_CODE
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [DATA_WIDTH-1:0]    data_line_in,
   output logic [3:0]               operation,
   output logic [ADDRESS_WIDTH-1:0] address_line,
   output logic                     busy,
   output logic                     done,
   rom_dump_sequencer_if.master     sample_if
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(LAST_ADDRESS);

   logic [1:0]               r_rst_sync;
   logic                     w_rst_n;
   seq_state_t               r_state;
   seq_state_t               w_state_next;
   logic                     w_timer_load;
   logic                     w_timer_expired;
   logic                     w_capture;
   logic                     w_advance;
   logic [ADDRESS_WIDTH-1:0] r_address;
   logic [DATA_WIDTH-1:0]    r_sample_data;
   logic [ADDRESS_WIDTH-1:0] r_sample_address;
   logic                     r_sample_valid;
   logic                     r_busy;
   logic                     r_done;
   logic [3:0]               r_operation;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   rom_access_timer #(
      .ACCESS_CYCLES (ACCESS_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (w_rst_n),
      .load    (w_timer_load),
      .expired (w_timer_expired)
   );

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_timer_load = 1'b0;
      w_capture    = 1'b0;
      w_advance    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_SETUP;
               w_timer_load = 1'b1;
            end
         end
         ST_SETUP: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (w_timer_expired) begin
               w_state_next = ST_PRESENT;
               w_capture    = 1'b1;
            end
         end
         ST_PRESENT: begin
            // A handshake on the abort edge still completes; the sweep just stops.
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (sample_if.sample_ready) begin
               if (r_address == LAST) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next = ST_SETUP;
                  w_timer_load = 1'b1;
                  w_advance    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so none depends combinationally on inputs.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_address        <= '0;
         r_sample_data    <= '0;
         r_sample_address <= '0;
         r_sample_valid   <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_operation      <= OP_IDLE;
      end else begin
         if (w_state_next == ST_IDLE) begin
            r_address <= '0;
         end else if (w_advance) begin
            r_address <= r_address + 1'b1;
         end
         if (w_capture) begin
            r_sample_data    <= data_line_in;
            r_sample_address <= r_address;
         end
         r_sample_valid <= (w_state_next == ST_PRESENT);
         r_busy         <= (w_state_next != ST_IDLE);
         r_done         <= (w_state_next == ST_DONE);
         r_operation    <= ((w_state_next == ST_SETUP) || (w_state_next == ST_PRESENT))
                           ? OP_READ : OP_IDLE;
      end
   end

   assign operation                = r_operation;
   assign address_line             = r_address;
   assign busy                     = r_busy;
   assign done                     = r_done;
   assign sample_if.sample_data    = r_sample_data;
   assign sample_if.sample_address = r_sample_address;
   assign sample_if.sample_valid   = r_sample_valid;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Self-checking bench: cycle table for the control flow, scoreboarded sweeps
// for both chip configurations, and hand-written corner-case sequences.
module tb_rom_dump_sequencer;
   import rom_reader_pkg::*;

   localparam int AW  = 9;
   localparam int DW  = 8;
   localparam int AC  = 4;
   localparam int LA  = 511;
   localparam int AW4 = 8;
   localparam int DW4 = 4;
   localparam int AC4 = 1;
   localparam int LA4 = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset_n;
   logic           start, abort;
   logic [DW-1:0]  data_line_in;
   logic [3:0]     operation;
   logic [AW-1:0]  address_line;
   logic           busy, done;

   logic           start4, abort4;
   logic [DW4-1:0] data4;
   logic [3:0]     op4;
   logic [AW4-1:0] addr4;
   logic           busy4, done4;

   rom_dump_sequencer_if #(.DATA_WIDTH(DW),  .ADDRESS_WIDTH(AW))  sif ();
   rom_dump_sequencer_if #(.DATA_WIDTH(DW4), .ADDRESS_WIDTH(AW4)) sif4 ();

   rom_dump_sequencer #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LAST_ADDRESS(LA), .ACCESS_CYCLES(AC),
      .OP_READ(4'b1100), .OP_IDLE(4'b1111)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .data_line_in(data_line_in), .operation(operation), .address_line(address_line),
      .busy(busy), .done(done), .sample_if(sif)
   );

   rom_dump_sequencer #(
      .DATA_WIDTH(DW4), .ADDRESS_WIDTH(AW4), .LAST_ADDRESS(LA4), .ACCESS_CYCLES(AC4),
      .OP_READ(4'b1100), .OP_IDLE(4'b1111)
   ) u_dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .abort(abort4),
      .data_line_in(data4), .operation(op4), .address_line(addr4),
      .busy(busy4), .done(done4), .sample_if(sif4)
   );

   // Chip models: contents are a fixed function of the address.
   assign data_line_in = address_line[7:0] ^ 8'hA5;
   assign data4        = addr4[3:0] ^ addr4[7:4] ^ 4'h9;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] data;
   } pair_t;

   pair_t q[$];
   pair_t q4[$];

   function automatic pair_t exp8(input int a);
      pair_t p;
      p.addr = a[8:0];
      p.data = a[7:0] ^ 8'hA5;
      return p;
   endfunction

   function automatic pair_t exp4(input int a);
      pair_t p;
      p.addr = a[8:0];
      p.data = {4'b0000, a[3:0] ^ a[7:4] ^ 4'h9};
      return p;
   endfunction

   int n_xfer = 0, n_xfer4 = 0, n_done = 0, n_done4 = 0, max_addr4 = 0;

   // Inputs change just after posedge, so valid&ready at negedge is what the next edge sees.
   always @(negedge clk) begin
      pair_t e;
      if (sif.sample_valid && sif.sample_ready) begin
         n_xfer++;
         if (q.size() == 0) begin
            check("xfer_unexpected", 32'(q.size()), 32'd1);
         end else begin
            e = q.pop_front();
            check("xfer_addr", 32'(sif.sample_address), 32'(e.addr));
            check("xfer_data", 32'(sif.sample_data), 32'(e.data));
         end
      end
      if (sif4.sample_valid && sif4.sample_ready) begin
         n_xfer4++;
         if (q4.size() == 0) begin
            check("xfer4_unexpected", 32'(q4.size()), 32'd1);
         end else begin
            e = q4.pop_front();
            check("xfer4_addr", 32'(sif4.sample_address), 32'(e.addr));
            check("xfer4_data", 32'(sif4.sample_data), 32'(e.data));
         end
      end
      if (done)  n_done++;
      if (done4) n_done4++;
      if (int'(addr4) > max_addr4) max_addr4 = int'(addr4);
   end

   typedef struct {
      bit         start;
      bit         abort;
      bit         ready;
      bit         busy;
      bit         valid;
      bit         done;
      logic [3:0] op;
      int         addr;
   } vec_t;

   vec_t vecs[14];

   task automatic wait_present(input int a, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (sif.sample_valid && (sif.sample_address == 9'(a))) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int cycles;
      int d0, x0;
      bit pulsed;

      //            start abort ready busy valid done op     addr
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 1};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 0};

      reset_n = 1'b0;
      start = 1'b0; abort = 1'b0; sif.sample_ready = 1'b0;
      start4 = 1'b0; abort4 = 1'b0; sif4.sample_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_op",       32'(operation), 32'hF);
      check("rst_addr",     32'(address_line), 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_done",     32'(done), 32'd0);
      check("rst_valid",    32'(sif.sample_valid), 32'd0);
      check("rst_sdata",    32'(sif.sample_data), 32'd0);
      check("rst_saddr",    32'(sif.sample_address), 32'd0);
      check("rst4_op",      32'(op4), 32'hF);
      check("rst4_addr",    32'(addr4), 32'd0);
      check("rst4_busy",    32'(busy4), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Cycle table: start/abort priority, access time, stall, abort in PRESENT.
      q.push_back(exp8(0));
      for (int i = 0; i < 14; i++) begin
         start = vecs[i].start; abort = vecs[i].abort; sif.sample_ready = vecs[i].ready;
         @(posedge clk); #1;
         check($sformatf("vec%0d_busy", i),  32'(busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d_valid", i), 32'(sif.sample_valid), 32'(vecs[i].valid));
         check($sformatf("vec%0d_done", i),  32'(done), 32'(vecs[i].done));
         check($sformatf("vec%0d_op", i),    32'(operation), 32'(vecs[i].op));
         check($sformatf("vec%0d_addr", i),  32'(address_line), 32'(vecs[i].addr));
      end
      start = 1'b0; abort = 1'b0; sif.sample_ready = 1'b0;
      check("vec_queue_empty", 32'(q.size()), 32'd0);

      // Backpressure at address 3.
      for (int a = 0; a <= 3; a++) q.push_back(exp8(a));
      sif.sample_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_present(3, 100, ok);
      check("bp_reached_3", 32'(ok), 32'd1);
      sif.sample_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(sif.sample_valid), 32'd1);
         check("bp_saddr", 32'(sif.sample_address), 32'd3);
         check("bp_sdata", 32'(sif.sample_data), 32'(exp8(3).data));
         check("bp_addr_line", 32'(address_line), 32'd3);
      end
      sif.sample_ready = 1'b1;
      cycles = 0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         cycles++;
         if (sif.sample_valid && sif.sample_address == 9'd4) begin
            ok = 1'b1;
            break;
         end
      end
      check("bp_addr4_seen", 32'(ok), 32'd1);
      check("bp_addr4_latency", 32'(cycles), 32'(AC + 1));
      sif.sample_ready = 1'b0; abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check("bp_abort_busy", 32'(busy), 32'd0);
      check("bp_queue_empty", 32'(q.size()), 32'd0);

      // Abort on the same edge as the handshake of address 7.
      for (int a = 0; a <= 7; a++) q.push_back(exp8(a));
      sif.sample_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_present(7, 200, ok);
      check("ab_reached_7", 32'(ok), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check("ab_busy",  32'(busy), 32'd0);
      check("ab_valid", 32'(sif.sample_valid), 32'd0);
      check("ab_op",    32'(operation), 32'hF);
      check("ab_addr",  32'(address_line), 32'd0);
      check("ab_queue_empty", 32'(q.size()), 32'd0);
      d0 = n_done; x0 = n_xfer;
      repeat (20) @(posedge clk);
      #1;
      check("ab_no_done",  32'(n_done - d0), 32'd0);
      check("ab_no_xfer",  32'(n_xfer - x0), 32'd0);
      check("ab_no_addr8", 32'(sif.sample_address == 9'd8), 32'd0);
      check("ab_idle",     32'(busy), 32'd0);

      // Asynchronous reset in SETUP of address 5.
      for (int a = 0; a <= 4; a++) q.push_back(exp8(a));
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (address_line == 9'd5) begin
            ok = 1'b1;
            break;
         end
      end
      check("rs_reached_5", 32'(ok), 32'd1);
      @(posedge clk); #2;
      check("rs_pre_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rs_op",    32'(operation), 32'hF);
      check("rs_addr",  32'(address_line), 32'd0);
      check("rs_busy",  32'(busy), 32'd0);
      check("rs_valid", 32'(sif.sample_valid), 32'd0);
      check("rs_queue_empty", 32'(q.size()), 32'd0);
      sif.sample_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("rs_stay_idle", 32'(busy), 32'd0);
      end
      check("rs_idle_op", 32'(operation), 32'hF);

      // Full IP3604 sweep, with start pulsed mid-sweep at address 100.
      for (int a = 0; a <= LA; a++) q.push_back(exp8(a));
      d0 = n_done; x0 = n_xfer;
      sif.sample_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cycles = 1; pulsed = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         cycles++;
         if (!pulsed && address_line == 9'd100) begin
            start = 1'b1;
            pulsed = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (!busy) break;
      end
      start = 1'b0;
      check("sw_start_pulsed", 32'(pulsed), 32'd1);
      check("sw_cycles",   32'(cycles), 32'((LA + 1) * (AC + 1) + 2));
      check("sw_done_once", 32'(n_done - d0), 32'd1);
      check("sw_xfers",    32'(n_xfer - x0), 32'(LA + 1));
      check("sw_queue_empty", 32'(q.size()), 32'd0);
      check("sw_last_saddr", 32'(sif.sample_address), 32'(LA));
      repeat (5) @(posedge clk);
      #1;
      check("sw_no_restart", 32'(busy), 32'd0);
      sif.sample_ready = 1'b0;

      // IP3601 configuration sweep.
      for (int a = 0; a <= LA4; a++) q4.push_back(exp4(a));
      sif4.sample_ready = 1'b1; start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
      cycles = 1;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         cycles++;
         if (!busy4) break;
      end
      check("c4_cycles",    32'(cycles), 32'((LA4 + 1) * (AC4 + 1) + 2));
      check("c4_done_once", 32'(n_done4), 32'd1);
      check("c4_xfers",     32'(n_xfer4), 32'(LA4 + 1));
      check("c4_queue_empty", 32'(q4.size()), 32'd0);
      check("c4_max_addr",  32'(max_addr4), 32'(LA4));
      check("c4_idle_op",   32'(op4), 32'hF);
      check("c4_idle_addr", 32'(addr4), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
